// File: rtl/boot_mem_responder.sv
// Instruction/data memory for the single-cycle MIPS core, plus a byte-serial
// boot loader that fills imem and holds the core in reset until the load ends.
module boot_mem_responder #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  input  logic        bootValid,
  input  logic [7:0]  bootData,
  output logic        bootReady,
  output logic        cpuReset,
  output logic        loadDone
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

  state_t      state, state_nx;
  logic [15:0] n;
  logic [16:0] idx;
  logic [1:0]  lane;
  logic [23:0] part;
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic        accept, last_word, imem_we, dmem_we;
  logic [31:0] word;
  logic        unused;

  assign unused = ^{PC[31:IAW+2], PC[1:0], ALUOut[31:DAW+2], ALUOut[1:0]};

  // Handshake flags come from the state register only.
  assign bootReady = (state != RUN);
  assign cpuReset  = (state != RUN);
  assign loadDone  = (state == RUN);

  assign accept    = bootValid && bootReady;
  assign word      = {bootData, part};
  assign last_word = ((idx + 17'd1) == {1'b0, n});
  // Words past the end of imem are consumed but dropped rather than wrapped.
  assign imem_we   = !reset && accept && (state == DATA) && (lane == 2'd3) &&
                     (int'(idx) < IMEM_WORDS);
  assign dmem_we   = MemWrite && (state == RUN);

  assign Instr    = imem[PC[IAW+1:2]];
  assign ReadData = dmem[ALUOut[DAW+1:2]];

  always_comb begin
    state_nx = state;
    case (state)
      HDR0: if (accept) state_nx = HDR1;
      HDR1: if (accept) state_nx = ({bootData, n[7:0]} == 16'd0) ? RUN : DATA;
      DATA: if (accept && lane == 2'd3 && last_word) state_nx = RUN;
      RUN:  state_nx = RUN;
      default: state_nx = HDR0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HDR0;
      n     <= '0;
      idx   <= '0;
      lane  <= '0;
      part  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        case (state)
          HDR0: n[7:0]  <= bootData;
          HDR1: begin
            n[15:8] <= bootData;
            idx     <= '0;
            lane    <= '0;
          end
          DATA: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: part[7:0]   <= bootData;
              2'd1: part[15:8]  <= bootData;
              2'd2: part[23:16] <= bootData;
              default: idx <= idx + 17'd1;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (imem_we) imem[idx[IAW-1:0]] <= word;
  end

  always_ff @(posedge clock) begin
    if (dmem_we) dmem[ALUOut[DAW+1:2]] <= WriteData;
  end
endmodule

// File: tb/tb_boot_mem_responder.sv
// Randomized scoreboard bench: a byte-count model of the loader predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_boot_mem_responder;
  localparam int IMEM_WORDS = 4;
  localparam int DMEM_WORDS = 16;

  logic        clock = 1'b0;
  logic        reset, MemWrite, bootValid;
  logic [31:0] PC, ALUOut, WriteData, Instr, ReadData;
  logic [7:0]  bootData;
  logic        bootReady, cpuReset, loadDone;

  boot_mem_responder #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clock(clock), .reset(reset), .PC(PC), .Instr(Instr), .ALUOut(ALUOut),
    .WriteData(WriteData), .MemWrite(MemWrite), .ReadData(ReadData),
    .bootValid(bootValid), .bootData(bootData), .bootReady(bootReady),
    .cpuReset(cpuReset), .loadDone(loadDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    bit          ik;
    logic [31:0] rd;
    bit          rk;
    bit          cr, br, ld;
  } exp_t;

  exp_t sb[$];
  int   total = 0, passed = 0;

  // Reference model: loader progress expressed as bytes accepted since reset.
  logic [31:0] mi [IMEM_WORDS];
  bit          mik[IMEM_WORDS];
  logic [31:0] md [DMEM_WORDS];
  bit          mdk[DMEM_WORDS];
  int          m_cnt = 0;
  logic [15:0] m_n = '0;
  bit          m_done = 1'b0;
  logic [31:0] m_wb = '0;
  bit          tog = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cpuReset", {31'd0, cpuReset}, {31'd0, e.cr});
      chk("bootReady", {31'd0, bootReady}, {31'd0, e.br});
      chk("loadDone", {31'd0, loadDone}, {31'd0, e.ld});
      if (e.ik) chk("Instr", Instr, e.instr);
      if (e.rk) chk("ReadData", ReadData, e.rd);
    end
  end

  // Drive one cycle, queue its expected outputs, then advance the model past the edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] b, input bit mw,
                      input logic [31:0] alu, input logic [31:0] wd,
                      input logic [31:0] pc, output bit acc);
    exp_t e;
    int ii, di, pos, wi;
    reset = rst; bootValid = v; bootData = b; MemWrite = mw;
    ALUOut = alu; WriteData = wd; PC = pc;
    ii = int'((pc >> 2) % IMEM_WORDS);
    di = int'((alu >> 2) % DMEM_WORDS);
    e.instr = mi[ii]; e.ik = mik[ii];
    e.rd = md[di];    e.rk = mdk[di];
    e.cr = !m_done; e.br = !m_done; e.ld = m_done;
    sb.push_back(e);
    acc = !rst && v && !m_done;
    if (rst) begin
      m_cnt = 0; m_n = '0; m_done = 1'b0; m_wb = '0;
    end else begin
      if (mw && m_done) begin md[di] = wd; mdk[di] = 1'b1; end
      if (acc) begin
        if (m_cnt == 0) m_n[7:0] = b;
        else if (m_cnt == 1) begin
          m_n[15:8] = b;
          if (m_n == 16'd0) m_done = 1'b1;
        end else begin
          pos = m_cnt - 2;
          wi  = pos / 4;
          m_wb[(pos % 4)*8 +: 8] = b;
          if (pos % 4 == 3) begin
            if (wi < IMEM_WORDS) begin mi[wi] = m_wb; mik[wi] = 1'b1; end
            if (wi + 1 == int'(m_n)) m_done = 1'b1;
          end
        end
        m_cnt++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit rst, input int cycles);
    bit acc;
    for (int i = 0; i < cycles; i++)
      step(rst, rst ? 1'b0 : 1'($urandom % 2), 8'($urandom), rst ? 1'b0 : 1'($urandom % 2),
           {26'($urandom), 4'($urandom), 2'($urandom)}, $urandom, $urandom, acc);
  endtask

  // mode 0: valid held, 1: toggled every cycle, 2: random valid
  task automatic send(input logic [7:0] q[$], input int mode);
    bit acc, v;
    int tries;
    foreach (q[k]) begin
      tries = 0;
      acc = 1'b0;
      while (!acc) begin
        tog = ~tog;
        v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom % 2);
        step(1'b0, v, q[k], 1'($urandom % 2), $urandom, $urandom, $urandom, acc);
        if (!acc && ++tries > 40) begin
          total++;
          $display("FAIL handshake: byte %0d not accepted within 40 cycles", k);
          return;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] basic[$], q[$];
    bit acc;
    int nw;
    basic = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    reset = 1'b1; bootValid = 1'b0; bootData = '0; MemWrite = 1'b0;
    PC = '0; ALUOut = '0; WriteData = '0;
    @(posedge clock); #1;

    // basic load, then fetch at PC 0/4/5
    idle(1'b1, 2);
    send(basic, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'd0, 32'd0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'd0, 32'd4, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'd0, 32'd5, acc);
    idle(1'b0, 8);

    // stores in RUN plus wrapped address
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'd8, 32'hAAAA5555, 32'd0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd8, 32'd0, 32'd0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd8 + 4*DMEM_WORDS, 32'd0, 32'd0, acc);

    // empty program, then ignored pulses in RUN
    idle(1'b1, 1);
    q = '{8'h00, 8'h00};
    send(q, 0);
    idle(1'b0, 6);

    // stores during a gapped load must not land in dmem[2]
    idle(1'b1, 1);
    foreach (basic[k]) begin
      acc = 1'b0;
      for (int t = 0; t < 4 && !acc; t++) begin
        tog = ~tog;
        step(1'b0, tog, basic[k], 1'b1, 32'd8, 32'h12121212, 32'd4, acc);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd8, 32'd0, 32'd0, acc);

    // overflow: 5 words into a 4-word imem
    idle(1'b1, 1);
    q = '{8'h05, 8'h00};
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    send(q, 0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'h00, 1'b0, 32'd0, 32'd0, 32'(4*i), acc);

    // reset mid-load then a fresh one-word load
    idle(1'b1, 1);
    q = basic[0:4];
    send(q, 0);
    idle(1'b1, 1);
    q = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send(q, 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 32'd0, 32'd0, acc);

    // random programs with random handshake gaps
    for (int r = 0; r < 6; r++) begin
      idle(1'b1, 1 + $urandom % 2);
      nw = $urandom % 7;
      q = '{8'(nw), 8'h00};
      for (int i = 0; i < 4*nw; i++) q.push_back(8'($urandom));
      send(q, $urandom % 3);
      idle(1'b0, 6);
    end

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
